// File: rtl/parking_pkg.sv
// Shared types and display constants for the parking gate controller.
// Seven-segment patterns are active-low in {g,f,e,d,c,b,a} order.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PASS,
        WRONG_PASS,
        RIGHT_PASS,
        STOP,
        FULL,
        LOCKOUT
    } state_t;

    localparam logic [6:0] HEX_BLANK = 7'b1111111;
    localparam logic [6:0] HEX_E     = 7'b0000110;
    localparam logic [6:0] HEX_N     = 7'b0101011;
    localparam logic [6:0] HEX_G     = 7'b1000010;
    localparam logic [6:0] HEX_O     = 7'b1000000;
    localparam logic [6:0] HEX_S     = 7'b0010010;
    localparam logic [6:0] HEX_P     = 7'b0001100;
    localparam logic [6:0] HEX_F     = 7'b0001110;
    localparam logic [6:0] HEX_L     = 7'b1000111;
    localparam logic [6:0] HEX_C     = 7'b1000110;

    // Returns {HEX_1, HEX_2} for a state.
    function automatic logic [13:0] state_hex(input state_t s);
        logic [13:0] h;
        h = {HEX_BLANK, HEX_BLANK};
        case (s)
            WAIT_PASS:  h = {HEX_E, HEX_N};
            WRONG_PASS: h = {HEX_E, HEX_E};
            RIGHT_PASS: h = {HEX_G, HEX_O};
            STOP:       h = {HEX_S, HEX_P};
            FULL:       h = {HEX_F, HEX_L};
            LOCKOUT:    h = {HEX_L, HEX_C};
            default:    h = {HEX_BLANK, HEX_BLANK};
        endcase
        return h;
    endfunction

    function automatic logic state_red(input state_t s, input logic blink);
        logic r;
        r = 1'b0;
        case (s)
            WAIT_PASS, STOP, FULL, LOCKOUT: r = 1'b1;
            WRONG_PASS:                     r = blink;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/parking_timer.sv
// Loadable down-counter that holds at zero; done is high while the count is zero.
// Shared by the password-entry window and the lockout period.
module parking_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking lot entry gate: password check with retry/lockout, occupancy tracking,
// tailgate detection, LED and seven-segment indication. All outputs are registered.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int                  PW_WIDTH    = 2,
    parameter logic [PW_WIDTH-1:0] PASS_1      = 2'b01,
    parameter logic [PW_WIDTH-1:0] PASS_2      = 2'b10,
    parameter int                  CAPACITY    = 4,
    parameter int                  WAIT_CYCLES = 3,
    parameter int                  MAX_TRIES   = 3,
    parameter int                  LOCK_CYCLES = 16,
    parameter int                  BLINK_DIV   = 2
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              sensor_entrance,
    input  logic                              sensor_exit,
    input  logic [PW_WIDTH-1:0]               password_1,
    input  logic [PW_WIDTH-1:0]               password_2,
    output logic                              GREEN_LED,
    output logic                              RED_LED,
    output logic [6:0]                        HEX_1,
    output logic [6:0]                        HEX_2,
    output logic [$clog2(CAPACITY+1)-1:0]     occupancy,
    output logic                              full,
    output logic                              lockout
);

    localparam int OCC_W   = $clog2(CAPACITY + 1);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);
    localparam int TMR_MAX = (WAIT_CYCLES > LOCK_CYCLES) ? WAIT_CYCLES : LOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int BLK_W   = $clog2(BLINK_DIV + 1);

    localparam logic [OCC_W-1:0] CAP_V     = OCC_W'(CAPACITY);
    localparam logic [TRY_W-1:0] MAX_V     = TRY_W'(MAX_TRIES);
    // Timer is loaded with N-1 so the state is held for exactly N cycles.
    localparam logic [TMR_W-1:0] WAIT_LOAD = TMR_W'(WAIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_DIV - 1);

    state_t             state, state_d;
    logic [OCC_W-1:0]   occ_d, occ_inc, occ_dec;
    logic [TRY_W-1:0]   tries, tries_d, tries_inc;
    logic               blink, blink_d;
    logic [BLK_W-1:0]   blink_cnt, blink_cnt_d;
    logic               tmr_load, tmr_done;
    logic [TMR_W-1:0]   tmr_value;
    logic               pw_match;

    assign pw_match  = (password_1 == PASS_1) && (password_2 == PASS_2);
    assign occ_inc   = (occupancy == CAP_V) ? occupancy : occupancy + 1'b1;
    assign occ_dec   = (occupancy == '0) ? occupancy : occupancy - 1'b1;
    assign tries_inc = (tries >= MAX_V) ? tries : tries + 1'b1;

    parking_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .load_value (tmr_value),
        .done       (tmr_done)
    );

    always_comb begin
        state_d   = state;
        occ_d     = occupancy;
        tries_d   = tries;
        tmr_load  = 1'b0;
        tmr_value = WAIT_LOAD;
        case (state)
            IDLE: begin
                // Entry decision uses the pre-decrement occupancy.
                if (sensor_exit) occ_d = occ_dec;
                if (sensor_entrance) begin
                    if (occupancy == CAP_V) begin
                        state_d = FULL;
                    end else begin
                        state_d  = WAIT_PASS;
                        tmr_load = 1'b1;
                    end
                end
            end
            WAIT_PASS: begin
                if (tmr_done) begin
                    if (pw_match) begin
                        state_d = RIGHT_PASS;
                        tries_d = '0;
                    end else begin
                        state_d  = WRONG_PASS;
                        tries_d  = tries_inc;
                        tmr_load = 1'b1;
                    end
                end
            end
            WRONG_PASS: begin
                if (tmr_done) begin
                    if (pw_match) begin
                        state_d = RIGHT_PASS;
                        tries_d = '0;
                    end else begin
                        tries_d  = tries_inc;
                        tmr_load = 1'b1;
                        if (tries_inc >= MAX_V) begin
                            state_d   = LOCKOUT;
                            tmr_value = LOCK_LOAD;
                        end
                    end
                end
            end
            RIGHT_PASS: begin
                if (sensor_exit) begin
                    occ_d   = occ_inc;
                    state_d = sensor_entrance ? STOP : IDLE;
                end
            end
            STOP: begin
                if (pw_match) begin
                    state_d = RIGHT_PASS;
                    tries_d = '0;
                end
            end
            FULL: begin
                if (sensor_exit) occ_d = occ_dec;
                if (!sensor_entrance) state_d = IDLE;
            end
            LOCKOUT: begin
                if (tmr_done) begin
                    state_d = IDLE;
                    tries_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Blink restarts high on entry to a blinking state; a WRONG_PASS retry is not an entry.
    always_comb begin
        blink_d     = 1'b0;
        blink_cnt_d = '0;
        if (state_d == RIGHT_PASS || state_d == WRONG_PASS) begin
            if (state_d != state) begin
                blink_d     = 1'b1;
                blink_cnt_d = '0;
            end else if (blink_cnt == BLK_LAST) begin
                blink_d     = ~blink;
                blink_cnt_d = '0;
            end else begin
                blink_d     = blink;
                blink_cnt_d = blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            occupancy <= '0;
            tries     <= '0;
            blink     <= 1'b0;
            blink_cnt <= '0;
            GREEN_LED <= 1'b0;
            RED_LED   <= 1'b0;
            HEX_1     <= HEX_BLANK;
            HEX_2     <= HEX_BLANK;
            full      <= 1'b0;
            lockout   <= 1'b0;
        end else begin
            state          <= state_d;
            occupancy      <= occ_d;
            tries          <= tries_d;
            blink          <= blink_d;
            blink_cnt      <= blink_cnt_d;
            GREEN_LED      <= (state_d == RIGHT_PASS) && blink_d;
            RED_LED        <= state_red(state_d, blink_d);
            {HEX_1, HEX_2} <= state_hex(state_d);
            full           <= (occ_d == CAP_V);
            lockout        <= (state_d == LOCKOUT);
        end
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl: directed stimulus pushes expected outputs,
// a monitor pops and compares after every clock edge or reset assertion.
module tb_parking_gate_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sensor_entrance = 1'b0;
    logic       sensor_exit = 1'b0;
    logic [1:0] password_1 = 2'b00;
    logic [1:0] password_2 = 2'b00;
    logic       GREEN_LED, RED_LED;
    logic [6:0] HEX_1, HEX_2;
    logic [2:0] occupancy;
    logic       full, lockout;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] OK1 = 2'b01;
    localparam logic [1:0] OK2 = 2'b10;
    localparam logic [1:0] BAD = 2'b00;

    typedef enum int {E_IDLE, E_WAIT, E_WRONG, E_RIGHT, E_STOP, E_FULL, E_LOCK} exp_st_t;

    typedef struct {
        string      tag;
        logic [6:0] h1;
        logic [6:0] h2;
        logic       g;
        logic       r;
        logic [2:0] occ;
        logic       fl;
        logic       lk;
    } exp_t;

    exp_t sb[$];

    parking_gate_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sensor_entrance (sensor_entrance),
        .sensor_exit     (sensor_exit),
        .password_1      (password_1),
        .password_2      (password_2),
        .GREEN_LED       (GREEN_LED),
        .RED_LED         (RED_LED),
        .HEX_1           (HEX_1),
        .HEX_2           (HEX_2),
        .occupancy       (occupancy),
        .full            (full),
        .lockout         (lockout)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] hex_of(input exp_st_t s);
        logic [13:0] h;
        case (s)
            E_WAIT:  h = {7'b0000110, 7'b0101011};
            E_WRONG: h = {7'b0000110, 7'b0000110};
            E_RIGHT: h = {7'b1000010, 7'b1000000};
            E_STOP:  h = {7'b0010010, 7'b0001100};
            E_FULL:  h = {7'b0001110, 7'b1000111};
            E_LOCK:  h = {7'b1000111, 7'b1000110};
            default: h = {7'b1111111, 7'b1111111};
        endcase
        return h;
    endfunction

    task automatic push_exp(input exp_st_t st, input logic g, input logic r,
                            input logic [2:0] occ, input string tag);
        exp_t e;
        e.tag = tag;
        {e.h1, e.h2} = hex_of(st);
        e.g   = g;
        e.r   = r;
        e.occ = occ;
        e.fl  = (occ == 3'd4);
        e.lk  = (st == E_LOCK);
        sb.push_back(e);
    endtask

    task automatic cyc(input logic se, input logic sx, input logic [1:0] p1, input logic [1:0] p2,
                       input exp_st_t st, input logic g, input logic r,
                       input logic [2:0] occ, input string tag);
        @(negedge clk);
        sensor_entrance = se;
        sensor_exit     = sx;
        password_1      = p1;
        password_2      = p2;
        push_exp(st, g, r, occ, tag);
    endtask

    task automatic car_in(input logic [2:0] o);
        cyc(1, 0, OK1, OK2, E_WAIT,  0, 1, o, "in_wait1");
        cyc(0, 0, OK1, OK2, E_WAIT,  0, 1, o, "in_wait2");
        cyc(0, 0, OK1, OK2, E_WAIT,  0, 1, o, "in_wait3");
        cyc(0, 0, OK1, OK2, E_RIGHT, 1, 0, o, "in_right");
        cyc(0, 1, OK1, OK2, E_IDLE,  0, 0, o + 3'd1, "in_idle");
    endtask

    task automatic check(input string tag, input string fld, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s got %0h expected %0h at %0t", tag, fld, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t m;
        forever begin
            @(posedge clk or negedge reset_n);
            #1;
            if (sb.size() != 0) begin
                m = sb.pop_front();
                check(m.tag, "HEX_1",     {1'b0, HEX_1},     {1'b0, m.h1});
                check(m.tag, "HEX_2",     {1'b0, HEX_2},     {1'b0, m.h2});
                check(m.tag, "GREEN_LED", {7'b0, GREEN_LED}, {7'b0, m.g});
                check(m.tag, "RED_LED",   {7'b0, RED_LED},   {7'b0, m.r});
                check(m.tag, "occupancy", {5'b0, occupancy}, {5'b0, m.occ});
                check(m.tag, "full",      {7'b0, full},      {7'b0, m.fl});
                check(m.tag, "lockout",   {7'b0, lockout},   {7'b0, m.lk});
            end
        end
    end

    initial begin : stimulus
        // Reset state while reset is held
        repeat (2) @(negedge clk);
        cyc(0, 0, BAD, BAD, E_IDLE, 0, 0, 3'd0, "reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Correct entry with blink pattern in RIGHT_PASS
        cyc(1, 0, OK1, OK2, E_WAIT,  0, 1, 3'd0, "ok_wait1");
        cyc(1, 0, OK1, OK2, E_WAIT,  0, 1, 3'd0, "ok_wait2");
        cyc(0, 0, OK1, OK2, E_WAIT,  0, 1, 3'd0, "ok_wait3");
        cyc(0, 0, OK1, OK2, E_RIGHT, 1, 0, 3'd0, "ok_right1");
        cyc(0, 0, OK1, OK2, E_RIGHT, 1, 0, 3'd0, "ok_right2");
        cyc(0, 0, OK1, OK2, E_RIGHT, 0, 0, 3'd0, "ok_right3");
        cyc(0, 1, OK1, OK2, E_IDLE,  0, 0, 3'd1, "ok_idle");

        // Three wrong samples lead to a 16-cycle lockout
        cyc(1, 0, BAD, BAD, E_WAIT,  0, 1, 3'd1, "bad_wait1");
        cyc(0, 0, BAD, BAD, E_WAIT,  0, 1, 3'd1, "bad_wait2");
        cyc(0, 0, BAD, BAD, E_WAIT,  0, 1, 3'd1, "bad_wait3");
        cyc(0, 0, BAD, BAD, E_WRONG, 0, 1, 3'd1, "bad_wrong1");
        cyc(0, 0, BAD, BAD, E_WRONG, 0, 1, 3'd1, "bad_wrong2");
        cyc(0, 0, BAD, BAD, E_WRONG, 0, 0, 3'd1, "bad_wrong3");
        cyc(0, 0, BAD, BAD, E_WRONG, 0, 0, 3'd1, "bad_wrong4");
        cyc(0, 0, BAD, BAD, E_WRONG, 0, 1, 3'd1, "bad_wrong5");
        cyc(0, 0, BAD, BAD, E_WRONG, 0, 1, 3'd1, "bad_wrong6");
        cyc(0, 0, BAD, BAD, E_LOCK,  0, 1, 3'd1, "lock_enter");
        for (int i = 0; i < 15; i++)
            cyc(1, 1, OK1, OK2, E_LOCK, 0, 1, 3'd1, "lock_hold");
        cyc(0, 0, BAD, BAD, E_IDLE, 0, 0, 3'd1, "lock_exit");

        // Fill the lot, then FULL handling
        car_in(3'd1);
        car_in(3'd2);
        car_in(3'd3);
        cyc(1, 0, OK1, OK2, E_FULL, 0, 1, 3'd4, "full_enter");
        cyc(1, 1, OK1, OK2, E_FULL, 0, 1, 3'd3, "full_exit");
        cyc(0, 0, OK1, OK2, E_IDLE, 0, 0, 3'd3, "full_leave");

        // Simultaneous entrance and exit at capacity
        car_in(3'd3);
        cyc(1, 1, OK1, OK2, E_FULL, 0, 1, 3'd3, "simul_full");
        cyc(0, 0, OK1, OK2, E_IDLE, 0, 0, 3'd3, "simul_idle");

        // Tailgate, then occupancy saturating at capacity
        cyc(1, 0, OK1, OK2, E_WAIT,  0, 1, 3'd3, "tg_wait1");
        cyc(0, 0, OK1, OK2, E_WAIT,  0, 1, 3'd3, "tg_wait2");
        cyc(0, 0, OK1, OK2, E_WAIT,  0, 1, 3'd3, "tg_wait3");
        cyc(0, 0, OK1, OK2, E_RIGHT, 1, 0, 3'd3, "tg_right");
        cyc(1, 1, BAD, BAD, E_STOP,  0, 1, 3'd4, "tg_stop");
        cyc(1, 1, BAD, BAD, E_STOP,  0, 1, 3'd4, "tg_hold");
        cyc(0, 0, OK1, OK2, E_RIGHT, 1, 0, 3'd4, "tg_right2");
        cyc(0, 1, OK1, OK2, E_IDLE,  0, 0, 3'd4, "tg_sat");
        cyc(0, 1, OK1, OK2, E_IDLE,  0, 0, 3'd3, "dec");

        // Reset asserted mid-cycle during WRONG_PASS
        cyc(1, 0, BAD, BAD, E_WAIT,  0, 1, 3'd3, "rw_wait1");
        cyc(0, 0, BAD, BAD, E_WAIT,  0, 1, 3'd3, "rw_wait2");
        cyc(0, 0, BAD, BAD, E_WAIT,  0, 1, 3'd3, "rw_wait3");
        cyc(0, 0, BAD, BAD, E_WRONG, 0, 1, 3'd3, "rw_wrong");
        @(negedge clk);
        push_exp(E_IDLE, 0, 0, 3'd0, "async_reset");
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Exit at zero occupancy saturates, then a normal entry starts
        cyc(0, 1, OK1, OK2, E_IDLE, 0, 0, 3'd0, "sat_zero");
        cyc(1, 0, OK1, OK2, E_WAIT, 0, 1, 3'd0, "post_reset");

        repeat (3) @(negedge clk);
        check("drain", "queue_left", 8'(sb.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
